// File: rtl/sel_mux_pkg.sv
// Shared state encoding, entry sizing and parameter legality for the select/skid pipeline.
package sel_mux_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Each buffered entry carries the select-error flag above the data bits.
  function automatic int entry_w(input int width);
    return width + 1;
  endfunction

  function automatic bit params_ok(input int num_in, input int sel_w);
    return (num_in >= 2) && ((1 << sel_w) >= num_in);
  endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Handshake bundle between the upstream decode stage and the downstream consumer.
interface sel_mux_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        oor_count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel_err, out_valid, oor_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel_err, out_valid, oor_count
  );

endinterface

// File: rtl/sel_skid_buf.sv
// Two-entry skid buffer: main register drives the output, skid catches one extra entry
// so in_ready can be a register with no combinational path from out_ready.
module sel_skid_buf #(
  parameter int EW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] in_entry,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [EW-1:0] out_entry,
  output logic          out_valid,
  input  logic          out_ready
);
  import sel_mux_pkg::*;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [EW-1:0] main_p1;
  logic [EW-1:0] skid_p1;
  logic          accept;
  logic          drain;
  logic          load_main_in;
  logic          load_main_skid;
  logic          load_skid;

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_entry = main_p1;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nx     = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nx  = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_nx       = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  // Stage p1: main register and control state; reset clears everything visible downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      main_p1  <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != ST_FULL);
      if (load_main_in) begin
        main_p1 <= in_entry;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_p1 <= in_entry;
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-to-1 select with out-of-range detection feeding a registered, backpressure-aware
// skid buffer; counts accepted out-of-range selects with saturation.
module sel_mux_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  sel_mux_pipe_if.slave  bus
);
  import sel_mux_pkg::*;

  localparam int EW = entry_w(WIDTH);

  generate
    if (!params_ok(NUM_IN, SEL_W)) begin : g_bad_params
      $error("sel_mux_pipe: need NUM_IN >= 2 and 2**SEL_W >= NUM_IN");
    end
  endgenerate

  logic [SEL_W:0]   sel_ext;
  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_err_p0;
  logic [EW-1:0]    entry_p1;
  logic             accept;
  logic [CNT_W-1:0] oor_count_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Compare one bit wider so NUM_IN == 2**SEL_W does not truncate to zero.
  assign sel_ext = {1'b0, bus.in_sel};

  // Stage p0: out-of-range selects fall back to the last input with the error flag set.
  always_comb begin
    sel_data_p0 = bus.in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    sel_err_p0  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == (SEL_W+1)'(k)) begin
        sel_data_p0 = bus.in_data[k*WIDTH +: WIDTH];
        sel_err_p0  = 1'b0;
      end
    end
  end

  sel_skid_buf #(
    .EW(EW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_entry  ({sel_err_p0, sel_data_p0}),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_entry (entry_p1),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign accept = bus.in_valid & bus.in_ready;

  // Stage p1: counter advances on the same edge the erroneous entry is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_count_q <= '0;
    end else if (accept && sel_err_p0) begin
      oor_count_q <= sat_inc(oor_count_q);
    end
  end

  assign bus.out_data    = entry_p1[WIDTH-1:0];
  assign bus.out_sel_err = entry_p1[WIDTH];
  assign bus.oor_count   = oor_count_q;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: directed scenarios on default/CNT_W=2 builds, random run on a
// 32-bit 5-input build against a queue-based reference model.
module tb_sel_mux_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  sel_mux_pipe_if #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2), .CNT_W(8)) b0 ();
  sel_mux_pipe_if #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2), .CNT_W(2)) b1 ();
  sel_mux_pipe_if #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .CNT_W(8)) b2 ();

  sel_mux_pipe #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  sel_mux_pipe #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
  sel_mux_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.in_data = '0; b0.in_sel = '0; b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    b1.in_data = '0; b1.in_sel = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    b2.in_data = '0; b2.in_sel = '0; b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", b0.out_valid); end
    n_cmp++; if (b0.out_data !== 5'd0) begin n_fail++; $display("FAIL rst_out_data: got %0d want 0", b0.out_data); end
    n_cmp++; if (b0.out_sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_sel_err: got %0b want 0", b0.out_sel_err); end
    n_cmp++; if (b0.oor_count !== 8'd0) begin n_fail++; $display("FAIL rst_oor_count: got %0d want 0", b0.oor_count); end
    rst = 1'b0;
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready0: got %0b want 1", b0.in_ready); end
    n_cmp++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready1: got %0b want 1", b1.in_ready); end
    n_cmp++; if (b2.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready2: got %0b want 1", b2.in_ready); end
    tick();
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %0b want 0", b0.out_valid); end
  endtask

  task automatic test_select();
    logic [4:0] exp_d [3];
    exp_d[0] = 5'd3; exp_d[1] = 5'd17; exp_d[2] = 5'd9;
    b0.in_data   = {5'd9, 5'd17, 5'd3};
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      b0.in_sel = 2'(s);
      tick();
      n_cmp++; if (b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL sel%0d_valid: got %0b want 1", s, b0.out_valid); end
      n_cmp++; if (b0.out_data !== exp_d[s]) begin n_fail++; $display("FAIL sel%0d_data: got %0d want %0d", s, b0.out_data, exp_d[s]); end
      n_cmp++; if (b0.out_sel_err !== 1'b0) begin n_fail++; $display("FAIL sel%0d_err: got %0b want 0", s, b0.out_sel_err); end
      n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL sel%0d_in_ready: got %0b want 1", s, b0.in_ready); end
    end
    b0.in_valid = 1'b0;
    tick();
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL sel_drained: got %0b want 0", b0.out_valid); end
  endtask

  task automatic test_out_of_range();
    b0.in_sel   = 2'b11;
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    n_cmp++; if (b0.out_data !== 5'd9) begin n_fail++; $display("FAIL oor_data: got %0d want 9", b0.out_data); end
    n_cmp++; if (b0.out_sel_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %0b want 1", b0.out_sel_err); end
    n_cmp++; if (b0.oor_count !== 8'd1) begin n_fail++; $display("FAIL oor_count: got %0d want 1", b0.oor_count); end
    tick();
  endtask

  task automatic test_backpressure();
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    b0.in_sel    = 2'd0;
    tick();
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_c1: got %0b want 1", b0.in_ready); end
    b0.in_sel = 2'd1;
    tick();
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c2: got %0b want 0", b0.in_ready); end
    n_cmp++; if (b0.out_data !== 5'd3) begin n_fail++; $display("FAIL bp_frozen_c2: got %0d want 3", b0.out_data); end
    b0.in_sel = 2'd2;
    tick();
    n_cmp++; if (b0.out_data !== 5'd3) begin n_fail++; $display("FAIL bp_frozen_c3: got %0d want 3", b0.out_data); end
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c3: got %0b want 0", b0.in_ready); end
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    tick();
    n_cmp++; if (b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %0b want 1", b0.out_valid); end
    n_cmp++; if (b0.out_data !== 5'd17) begin n_fail++; $display("FAIL bp_second_data: got %0d want 17", b0.out_data); end
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_free: got %0b want 1", b0.in_ready); end
    tick();
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %0b want 0", b0.out_valid); end
    n_cmp++; if (b0.oor_count !== 8'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", b0.oor_count); end
  endtask

  task automatic test_reset_mid_stream();
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    b0.in_sel    = 2'b11;
    tick();
    b0.in_sel = 2'd0;
    tick();
    b0.in_valid = 1'b0;
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %0b want 0", b0.in_ready); end
    n_cmp++; if (b0.oor_count !== 8'd2) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 2", b0.oor_count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", b0.out_valid); end
    n_cmp++; if (b0.oor_count !== 8'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", b0.oor_count); end
    n_cmp++; if (b0.out_data !== 5'd0) begin n_fail++; $display("FAIL mid_data: got %0d want 0", b0.out_data); end
    tick();
    rst = 1'b0;
    b0.out_ready = 1'b1;
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b want 1", b0.in_ready); end
    tick();
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got %0b want 0", b0.out_valid); end
  endtask

  task automatic test_saturate();
    int exp_c;
    b1.in_data   = 15'($urandom);
    b1.out_ready = 1'b1;
    b1.in_valid  = 1'b1;
    b1.in_sel    = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_c = (k < 3) ? k : 3;
      n_cmp++; if (b1.oor_count !== 2'(exp_c)) begin n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", k, b1.oor_count, exp_c); end
      n_cmp++; if (b1.out_sel_err !== 1'b1) begin n_fail++; $display("FAIL sat_err%0d: got %0b want 1", k, b1.out_sel_err); end
    end
    b1.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [31:0] words [5];
    logic [32:0] e;
    int          cnt;
    bit          pending;
    bit          acc;
    bit          drn;
    int          s;
    cnt     = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      n_cmp++; if (b2.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %0b want %0b", cyc, b2.in_ready, q.size() < 2); end
      n_cmp++; if (b2.out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %0b want %0b", cyc, b2.out_valid, q.size() > 0); end
      n_cmp++; if (b2.oor_count !== 8'(cnt)) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, b2.oor_count, cnt); end
      if (q.size() > 0) begin
        n_cmp++; if (b2.out_data !== q[0][31:0]) begin n_fail++; $display("FAIL rnd_data c%0d: got %0h want %0h", cyc, b2.out_data, q[0][31:0]); end
        n_cmp++; if (b2.out_sel_err !== q[0][32]) begin n_fail++; $display("FAIL rnd_err c%0d: got %0b want %0b", cyc, b2.out_sel_err, q[0][32]); end
      end
      if (!pending) begin
        b2.in_valid = ($urandom_range(0, 3) != 0);
        s = $urandom_range(0, 7);
        for (int k = 0; k < 5; k++) words[k] = $urandom;
        b2.in_data = {words[4], words[3], words[2], words[1], words[0]};
        b2.in_sel  = 3'(s);
      end
      b2.out_ready = ($urandom_range(0, 3) != 0);
      acc = b2.in_valid && (q.size() < 2);
      drn = (q.size() > 0) && b2.out_ready;
      e   = (s < 5) ? {1'b0, words[s]} : {1'b1, words[4]};
      tick();
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e[32] && cnt < 255) cnt++;
      end
      pending = b2.in_valid && !acc;
    end
    b2.in_valid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_select();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_stream();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
